// File: rtl/wb_writeback.sv
// MIPS write-back stage: 2-entry result buffer that feeds the register-file write port.
// Optional `WB_BYPASS_EN exposes the youngest pending register write to decode.
module wb_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [1:0]        in_load_size,
    input  logic              in_load_signed,
    input  logic [1:0]        in_byte_off,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ack,
`ifdef WB_BYPASS_EN
    output logic              byp_valid,
    output logic [ADDR_W-1:0] byp_addr,
    output logic [DATA_W-1:0] byp_data,
`endif
    output logic [31:0]       retire_count
);

    logic              eff_q  [2];
    logic [ADDR_W-1:0] dest_q [2];
    logic [DATA_W-1:0] data_q [2];

    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] retire_q, retire_d;

    logic [DATA_W-1:0] fmt_data;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic              in_eff;
    logic              head_eff;
    logic              push;
    logic              pop;

    // Load extraction and extension are done once, at enqueue.
    always_comb begin
        half_sel = in_byte_off[1] ? in_mem_data[31:16] : in_mem_data[15:0];
        byte_sel = in_mem_data[8*in_byte_off +: 8];
        fmt_data = in_alu_result;
        if (in_mem_to_reg) begin
            case (in_load_size)
                2'b01:   fmt_data = {{(DATA_W-16){in_load_signed & half_sel[15]}}, half_sel};
                2'b10:   fmt_data = {{(DATA_W-8){in_load_signed & byte_sel[7]}}, byte_sel};
                default: fmt_data = in_mem_data;
            endcase
        end
    end

    // Writes to r0 are folded into a single "effective" flag so the head logic stays simple.
    assign in_eff   = in_reg_write && (in_dest != '0);
    assign in_ready = (cnt_q != 2'd2);
    assign push     = in_valid && in_ready;
    assign head_eff = (cnt_q != 2'd0) && eff_q[rd_ptr_q];
    assign pop      = (cnt_q != 2'd0) && (!head_eff || rf_ack);

    always_comb begin
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        retire_d = pop  ? retire_q + 32'd1 : retire_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            retire_q <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            retire_q <= retire_d;
        end
    end

    // Slot payload needs no reset: it is only visible when the slot is occupied.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == gi[0])) begin
                eff_q[gi]  <= in_eff;
                dest_q[gi] <= in_dest;
                data_q[gi] <= fmt_data;
            end
        end
    end

    assign rf_we        = head_eff;
    assign rf_waddr     = head_eff ? dest_q[rd_ptr_q] : '0;
    assign rf_wdata     = head_eff ? data_q[rd_ptr_q] : '0;
    assign retire_count = retire_q;

`ifdef WB_BYPASS_EN
    logic young_eff;
    logic tail_idx;

    // With two entries the tail is the younger one and takes priority over the head.
    assign tail_idx  = ~rd_ptr_q;
    assign young_eff = (cnt_q == 2'd2) && eff_q[tail_idx];
    assign byp_valid = young_eff || head_eff;
    assign byp_addr  = young_eff ? dest_q[tail_idx] : (head_eff ? dest_q[rd_ptr_q] : '0);
    assign byp_data  = young_eff ? data_q[tail_idx] : (head_eff ? data_q[rd_ptr_q] : '0);
`endif

endmodule

// File: tb/tb_wb_writeback.sv
// Scoreboard bench for wb_writeback: driver queues expected writes, monitor checks commits.
module tb_wb_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_reg_write, in_mem_to_reg, in_load_signed;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_result, in_mem_data;
    logic [1:0]  in_load_size, in_byte_off;
    logic        rf_we, rf_ack;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, retire_count;
`ifdef WB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_addr;
    logic [31:0] byp_data;
`endif

    always #5 clk = ~clk;

    wb_writeback #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_dest(in_dest), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .in_load_size(in_load_size), .in_load_signed(in_load_signed), .in_byte_off(in_byte_off),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ack(rf_ack),
`ifdef WB_BYPASS_EN
        .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
`endif
        .retire_count(retire_count)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t  expq[$];
    int   total = 0;
    int   bad = 0;
    int   accepted = 0;
    logic rand_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Reference formatting from the load rules, done with shifts and modulo arithmetic.
    function automatic logic [31:0] ref_fmt(input logic m2r, input logic [31:0] alu,
                                            input logic [31:0] mem, input logic [1:0] size,
                                            input logic sgn, input logic [1:0] off);
        longint v;
        if (!m2r) return alu;
        if (size == 2'd1) begin
            v = (longint'(mem) >> (16 * (int'(off) / 2))) % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end else if (size == 2'd2) begin
            v = (longint'(mem) >> (8 * int'(off))) % 256;
            if (sgn && v >= 128) v = v - 256;
        end else begin
            v = longint'(mem);
        end
        return v[31:0];
    endfunction

    // Monitor: every committed write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_we === 1'b1 && rf_ack === 1'b1) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected none", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = expq.pop_front();
                check("wr_addr", {27'd0, rf_waddr}, {27'd0, e.a});
                check("wr_data", rf_wdata, e.d);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the item.
    task automatic send(input logic rw, input logic m2r, input logic [4:0] dest,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] size,
                        input logic sgn, input logic [1:0] off,
                        input logic use_exp, input logic [31:0] exp_d);
        int  guard;
        wr_t e;
        guard          = 0;
        in_valid       = 1'b1;
        in_reg_write   = rw;
        in_mem_to_reg  = m2r;
        in_dest        = dest;
        in_alu_result  = alu;
        in_mem_data    = mem;
        in_load_size   = size;
        in_load_signed = sgn;
        in_byte_off    = off;
        @(negedge clk);
        while (in_ready !== 1'b1) begin
            guard++;
            if (guard > 300) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got in_ready=%b expected 1", in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (rw && dest != 5'd0) begin
            e.a = dest;
            e.d = use_exp ? exp_d : ref_fmt(m2r, alu, mem, size, sgn, off);
            expq.push_back(e);
        end
        accepted++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_alu(input logic [4:0] dest, input logic [31:0] alu);
        send(1'b1, 1'b0, dest, alu, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0);
    endtask

    task automatic send_load(input logic [1:0] size, input logic sgn, input logic [1:0] off,
                             input logic [31:0] exp_d);
        send(1'b1, 1'b1, 5'd12, 32'h0, 32'h8081F2F3, size, sgn, off, 1'b1, exp_d);
    endtask

    task automatic drain();
        int g;
        g      = 0;
        rf_ack = 1'b1;
        while (expq.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
            expq.delete();
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
        in_dest = '0; in_alu_result = '0; in_mem_data = '0; in_load_size = '0;
        in_load_signed = 1'b0; in_byte_off = '0; rf_ack = 1'b0; rand_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_retire", retire_count, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word ALU path and first-result latency.
        rf_ack = 1'b1;
        send_alu(5'd5, 32'hDEADBEEF);
        check("lat_we", {31'd0, rf_we}, 32'd1);
        check("lat_waddr", {27'd0, rf_waddr}, 32'd5);
        drain();
        check("retire_word", retire_count, 32'd1);

        send_load(2'd2, 1'b1, 2'd2, 32'hFFFFFF81);
        send_load(2'd2, 1'b0, 2'd2, 32'h00000081);
        send_load(2'd1, 1'b1, 2'd0, 32'hFFFFF2F3);
        send_load(2'd1, 1'b0, 2'd2, 32'h00008081);
        drain();
        check("retire_loads", retire_count, 32'(accepted));

        // Backpressure: head must hold while unacknowledged.
        rf_ack = 1'b0;
        send_alu(5'd20, 32'h11111111);
        send_alu(5'd21, 32'h22222222);
        check("bp_ready_low", {31'd0, in_ready}, 32'd0);
        fork
            send_alu(5'd22, 32'h33333333);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold_addr", {27'd0, rf_waddr}, 32'd20);
                    check("bp_hold_data", rf_wdata, 32'h11111111);
                end
                @(posedge clk); #1;
                rf_ack = 1'b1;
            end
        join
        drain();
        check("bp_ready_high", {31'd0, in_ready}, 32'd1);
        check("retire_bp", retire_count, 32'(accepted));

        // Non-effective entries retire without a write, even with no acknowledge.
        rf_ack = 1'b0;
        send(1'b1, 1'b0, 5'd0, 32'hAAAA5555, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0);
        send(1'b0, 1'b0, 5'd7, 32'h5555AAAA, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("noeff_we", {31'd0, rf_we}, 32'd0);
        check("retire_noeff", retire_count, 32'(accepted));
        @(posedge clk); #1;

`ifdef WB_BYPASS_EN
        rf_ack = 1'b0;
        send_alu(5'd3, 32'd1);
        send_alu(5'd3, 32'd2);
        check("byp_valid", {31'd0, byp_valid}, 32'd1);
        check("byp_addr", {27'd0, byp_addr}, 32'd3);
        check("byp_data", byp_data, 32'd2);
        drain();
`endif

        // Randomized traffic with random acknowledge.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                         5'($urandom_range(0, 31)), $urandom, $urandom,
                         2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                         2'($urandom_range(0, 3)), 1'b0, 32'h0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    rf_ack = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        check("retire_random", retire_count, 32'(accepted));

        // Asynchronous reset with two entries buffered.
        rf_ack = 1'b0;
        send_alu(5'd9, 32'h99999999);
        send_alu(5'd10, 32'hAAAAAAAA);
        check("full_before_rst", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", {31'd0, rf_we}, 32'd0);
        check("arst_retire", retire_count, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd1);
        expq.delete();
        accepted = 0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rf_ack = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_we", {31'd0, rf_we}, 32'd0);
        check("post_rst_retire", retire_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
